// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Optional feature macro: CTRL_JAL_EN (adds the jal instruction and its JAL state).
package control_pkg;

    // Controller states; the 4-bit encoding is visible on state_dbg
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
`ifdef CTRL_JAL_EN
        S_JAL      = 4'd10,
`endif
        S_TRAP     = 4'd11
    } state_t;

    // Opcode values (instruction[6:0])
    localparam int unsigned OP_LOAD   = 3;
    localparam int unsigned OP_STORE  = 35;
    localparam int unsigned OP_RTYPE  = 51;
    localparam int unsigned OP_ITYPE  = 19;
    localparam int unsigned OP_BRANCH = 99;
    localparam int unsigned OP_JAL    = 111;

    // result_src
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEMDAT = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // alu_src_a
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // imm_src
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // alu_op
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/control_imm_decoder.sv
// Combinational opcode -> immediate-format mapping for the immediate generator.
module control_imm_decoder
    import control_pkg::*;
#(
    parameter int OPCODE_W  = 7,
    parameter int IMM_SRC_W = 2
) (
    input  logic [OPCODE_W-1:0]  opcode,
    output logic [IMM_SRC_W-1:0] imm_src
);

    // Unknown opcodes fall back to I-format; the FSM traps them anyway
    always_comb begin
        imm_src = IMM_SRC_W'(IMM_I);
        if (opcode == OPCODE_W'(OP_STORE))
            imm_src = IMM_SRC_W'(IMM_S);
        else if (opcode == OPCODE_W'(OP_BRANCH))
            imm_src = IMM_SRC_W'(IMM_B);
        else if (opcode == OPCODE_W'(OP_JAL))
            imm_src = IMM_SRC_W'(IMM_J);
    end

endmodule

// File: rtl/control_multicycle_fsm.sv
// Multicycle Moore controller: fetch/decode/execute/memory/writeback sequencing
// with a mem_ready handshake and a memory watchdog.
// Optional feature macro: CTRL_JAL_EN (decodes jal, adds the JAL state).
module control_multicycle_fsm
    import control_pkg::*;
#(
    parameter int OPCODE_W    = 7,
    parameter int ALU_OP_W    = 2,
    parameter int IMM_SRC_W   = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [IMM_SRC_W-1:0] imm_src,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 illegal_op,
    output logic                 mem_timeout,
    output logic [3:0]           state_dbg
);

    state_t           state;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W:0]   wd_inc;
    logic             waiting;
    logic             expire;
    logic             pc_update;
    logic             branch;
    logic             ir_write_s;
    logic             mem_write_s;
    logic             reg_write_s;

    // Watchdog only advances in states that wait on memory
    assign waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign wd_inc  = {1'b0, wd_cnt} + 1'b1;
    assign expire  = (MEM_TIMEOUT != 0) && (wd_inc == (CNT_W+1)'(MEM_TIMEOUT));

    // State register, watchdog counter and sticky fault flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            wd_cnt      <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            wd_cnt <= '0;
            unique case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OPCODE_W'(OP_LOAD) || opcode == OPCODE_W'(OP_STORE))
                        state <= S_MEMADR;
                    else if (opcode == OPCODE_W'(OP_RTYPE))
                        state <= S_EXECUTER;
                    else if (opcode == OPCODE_W'(OP_ITYPE))
                        state <= S_EXECUTEI;
                    else if (opcode == OPCODE_W'(OP_BRANCH))
                        state <= S_BEQ;
`ifdef CTRL_JAL_EN
                    else if (opcode == OPCODE_W'(OP_JAL))
                        state <= S_JAL;
`endif
                    else begin
                        state      <= S_TRAP;
                        illegal_op <= 1'b1;
                    end
                end
                S_MEMADR:   state <= (opcode == OPCODE_W'(OP_LOAD)) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
`ifdef CTRL_JAL_EN
                S_JAL:      state <= S_ALUWB;
`endif
                default:    state <= S_TRAP;
            endcase
            // A stalled wait state either counts on or expires into TRAP;
            // mem_ready in the expiry cycle takes the normal path above.
            if (waiting && !mem_ready) begin
                if (expire) begin
                    state       <= S_TRAP;
                    mem_timeout <= 1'b1;
                end else begin
                    wd_cnt <= wd_inc[CNT_W-1:0];
                end
            end
        end
    end

    // Moore decode of datapath controls; enables are masked while in reset
    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALU_OP_W'(ALUOP_ADD);
        unique case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write_s = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RES_MEMDAT;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_W'(ALUOP_FUNCT);
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_W'(ALUOP_FUNCT);
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_W'(ALUOP_SUB);
                branch    = 1'b1;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pc_write  = rst_n & (pc_update | (branch & zero));
    assign ir_write  = rst_n & ir_write_s;
    assign mem_write = rst_n & mem_write_s;
    assign reg_write = rst_n & reg_write_s;
    assign state_dbg = state;

    control_imm_decoder #(
        .OPCODE_W  (OPCODE_W),
        .IMM_SRC_W (IMM_SRC_W)
    ) u_imm_dec (
        .opcode  (opcode),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_control_multicycle_fsm.sv
// Directed self-checking bench for control_multicycle_fsm (watchdog set to 4).
module tb_control_multicycle_fsm;
    import control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
    logic       illegal_op, mem_timeout;
    logic [3:0] state_dbg;

    int passed = 0;
    int total  = 0;

    control_multicycle_fsm #(
        .OPCODE_W(7), .ALU_OP_W(2), .IMM_SRC_W(2), .MEM_TIMEOUT(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_op(alu_op),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'd3;
        #3;
        total++; if (state_dbg !== 4'd0) $display("FAIL rst_state: got %0d exp 0", state_dbg); else passed++;
        total++; if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0) $display("FAIL rst_enables: got %b exp 0000", {pc_write, ir_write, mem_write, reg_write}); else passed++;
        total++; if ({alu_src_b, result_src} !== 4'b1010) $display("FAIL rst_selects: got %b exp 1010", {alu_src_b, result_src}); else passed++;
        total++; if ({illegal_op, mem_timeout} !== 2'b00) $display("FAIL rst_faults: got %b exp 00", {illegal_op, mem_timeout}); else passed++;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_lw();
        opcode = 7'd3; mem_ready = 1'b1; #1;
        total++; if ({state_dbg, ir_write, pc_write} !== 6'b0000_11) $display("FAIL lw_fetch: got %b exp 000011", {state_dbg, ir_write, pc_write}); else passed++;
        tick();
        total++; if ({state_dbg, alu_src_a, alu_src_b, imm_src} !== 10'b0001_01_01_00) $display("FAIL lw_decode: got %b exp 0001010100", {state_dbg, alu_src_a, alu_src_b, imm_src}); else passed++;
        tick();
        total++; if ({state_dbg, alu_src_a, alu_src_b} !== 8'b0010_10_01) $display("FAIL lw_memadr: got %b exp 00101001", {state_dbg, alu_src_a, alu_src_b}); else passed++;
        tick();
        total++; if ({state_dbg, adr_src} !== 5'b0011_1) $display("FAIL lw_memread: got %b exp 00111", {state_dbg, adr_src}); else passed++;
        tick();
        total++; if ({state_dbg, reg_write, result_src} !== 7'b0100_1_01) $display("FAIL lw_memwb: got %b exp 0100101", {state_dbg, reg_write, result_src}); else passed++;
        tick();
        total++; if (state_dbg !== 4'd0) $display("FAIL lw_next_fetch: got %0d exp 0", state_dbg); else passed++;
    endtask

    task automatic test_sw();
        int wr_cycles = 0;
        int hs_cycles = 0;
        opcode = 7'd35; mem_ready = 1'b1; #1;
        tick();
        total++; if ({state_dbg, imm_src} !== 6'b0001_01) $display("FAIL sw_decode: got %b exp 000101", {state_dbg, imm_src}); else passed++;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            total++; if ({state_dbg, adr_src} !== 5'b0101_1) $display("FAIL sw_memwrite_state: cycle %0d got %b exp 01011", i, {state_dbg, adr_src}); else passed++;
            if (mem_write) wr_cycles++;
            if (mem_write && mem_ready) hs_cycles++;
            tick();
        end
        total++; if (wr_cycles !== 4) $display("FAIL sw_write_cycles: got %0d exp 4", wr_cycles); else passed++;
        total++; if (hs_cycles !== 1) $display("FAIL sw_handshake_cycles: got %0d exp 1", hs_cycles); else passed++;
        total++; if ({state_dbg, mem_write} !== 5'b0000_0) $display("FAIL sw_next_fetch: got %b exp 00000", {state_dbg, mem_write}); else passed++;
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            opcode = 7'd99; mem_ready = 1'b1; zero = 1'b0; #1;
            tick();
            total++; if (imm_src !== 2'b10) $display("FAIL beq_imm: got %b exp 10", imm_src); else passed++;
            tick();
            zero = z[0]; #1;
            total++; if ({state_dbg, alu_op, alu_src_a} !== 8'b1001_01_10) $display("FAIL beq_state: got %b exp 10010110", {state_dbg, alu_op, alu_src_a}); else passed++;
            total++; if (pc_write !== z[0]) $display("FAIL beq_pc_write_z%0d: got %b exp %b", z, pc_write, z[0]); else passed++;
            tick();
            total++; if (state_dbg !== 4'd0) $display("FAIL beq_next_fetch_z%0d: got %0d exp 0", z, state_dbg); else passed++;
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        opcode = 7'd51; mem_ready = 1'b1; #1;
        tick();
        tick();
        total++; if ({state_dbg, alu_src_a, alu_src_b, alu_op} !== 10'b0110_10_00_10) $display("FAIL r_execute: got %b exp 0110100010", {state_dbg, alu_src_a, alu_src_b, alu_op}); else passed++;
        tick();
        total++; if ({state_dbg, reg_write, result_src} !== 7'b1000_1_00) $display("FAIL r_aluwb: got %b exp 1000100", {state_dbg, reg_write, result_src}); else passed++;
        tick();
        opcode = 7'd19; #1;
        tick();
        tick();
        total++; if ({state_dbg, alu_src_a, alu_src_b, alu_op} !== 10'b0111_10_01_10) $display("FAIL i_execute: got %b exp 0111100110", {state_dbg, alu_src_a, alu_src_b, alu_op}); else passed++;
        tick();
        tick();
        total++; if (state_dbg !== 4'd0) $display("FAIL i_next_fetch: got %0d exp 0", state_dbg); else passed++;
    endtask

    task automatic test_illegal(input logic [6:0] op);
        opcode = op; mem_ready = 1'b1; #1;
        tick();
        tick();
        total++; if ({state_dbg, illegal_op} !== 5'b1011_1) $display("FAIL illegal_trap_%0d: got %b exp 10111", op, {state_dbg, illegal_op}); else passed++;
        total++; if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0) $display("FAIL illegal_enables_%0d: got %b exp 0000", op, {pc_write, ir_write, mem_write, reg_write}); else passed++;
        repeat (3) tick();
        total++; if (state_dbg !== 4'd11) $display("FAIL illegal_hold_%0d: got %0d exp 11", op, state_dbg); else passed++;
        apply_reset();
        total++; if ({state_dbg, illegal_op} !== 5'b0000_0) $display("FAIL illegal_clear_%0d: got %b exp 00000", op, {state_dbg, illegal_op}); else passed++;
    endtask

`ifdef CTRL_JAL_EN
    task automatic test_jal();
        opcode = 7'd111; mem_ready = 1'b1; #1;
        tick();
        tick();
        total++; if ({state_dbg, pc_write, alu_src_a, alu_src_b, result_src, imm_src} !== 13'b1010_1_01_10_00_11) $display("FAIL jal_state: got %b", {state_dbg, pc_write, alu_src_a, alu_src_b, result_src, imm_src}); else passed++;
        tick();
        total++; if ({state_dbg, reg_write} !== 5'b1000_1) $display("FAIL jal_link: got %b exp 10001", {state_dbg, reg_write}); else passed++;
        tick();
        total++; if (state_dbg !== 4'd0) $display("FAIL jal_next_fetch: got %0d exp 0", state_dbg); else passed++;
    endtask
`endif

    task automatic test_timeout();
        apply_reset();
        opcode = 7'd51; mem_ready = 1'b0; #1;
        repeat (3) tick();
        total++; if ({state_dbg, mem_timeout, ir_write} !== 6'b0000_00) $display("FAIL wd_before_expiry: got %b exp 000000", {state_dbg, mem_timeout, ir_write}); else passed++;
        tick();
        total++; if ({state_dbg, mem_timeout, illegal_op} !== 6'b1011_10) $display("FAIL wd_expired: got %b exp 101110", {state_dbg, mem_timeout, illegal_op}); else passed++;
        apply_reset();
        total++; if (mem_timeout !== 1'b0) $display("FAIL wd_clear: got %b exp 0", mem_timeout); else passed++;
        repeat (3) tick();
        mem_ready = 1'b1; #1;
        tick();
        total++; if ({state_dbg, mem_timeout} !== 5'b0001_0) $display("FAIL wd_ready_wins: got %b exp 00010", {state_dbg, mem_timeout}); else passed++;
        tick();
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        opcode = 7'd35; mem_ready = 1'b1; #1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0; #1;
        total++; if ({state_dbg, mem_write} !== 5'b0101_1) $display("FAIL ar_in_memwrite: got %b exp 01011", {state_dbg, mem_write}); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({state_dbg, mem_write} !== 5'b0000_0) $display("FAIL ar_write_dropped: got %b exp 00000", {state_dbg, mem_write}); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (state_dbg !== 4'd0) $display("FAIL ar_after_release: got %0d exp 0", state_dbg); else passed++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_rtype();
        test_illegal(7'h7F);
`ifdef CTRL_JAL_EN
        test_jal();
`else
        test_illegal(7'd111);
`endif
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_multicycle_fsm.md
Name: control_multicycle_fsm

Overview:
- Multicycle successor to the single-cycle main decoder.
- A Moore state machine sequences fetch, decode, execute, memory and writeback over several cycles.
- It drives datapath mux selects and write enables; a `mem_ready` handshake supports a shared, variable-latency instruction/data memory.
- Sits in the control unit beside the ALU decoder, which consumes `alu_op`.

Parameters:
- OPCODE_W, 7, opcode field width.
- ALU_OP_W, 2, width of `alu_op` to the ALU decoder.
- IMM_SRC_W, 2, width of `imm_src`.
- MEM_TIMEOUT, 255, consecutive wait cycles before a timeout fault; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W-1 >= MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  instruction[6:0] taken from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory accepted the write / read data valid this cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = result.
- ir_write  out  1  IR/old_pc load enable.
- mem_write  out  1  memory write request.
- reg_write  out  1  register-file write enable.
- result_src  out  2  result select: 00 = alu_out reg, 01 = mem data reg, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1 reg.
- alu_src_b  out  2  ALU B select: 00 = rs2 reg, 01 = immediate, 10 = constant 4.
- imm_src  out  IMM_SRC_W  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_op  out  ALU_OP_W  00 = add, 01 = sub/compare, 10 = funct-decoded.
- illegal_op  out  1  sticky fault: unsupported opcode.
- mem_timeout  out  1  sticky fault: watchdog expired.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: while rst_n=0, state=FETCH, watchdog counter=0, both fault flags=0.
- All enables are forced 0 during reset: pc_write, ir_write, mem_write, reg_write.
- Selects take their FETCH values during reset.
- Outputs are a combinational function of the state register only, except:
  - `imm_src` decodes from `opcode` (lw/addi=00, sw=01, beq=10, jal=11, others 00).
  - pc_write = pc_update | (branch & zero).
  - ir_write and FETCH pc_update are gated by mem_ready.
- Defaults in every state: all enables 0, adr_src=0, result_src=00, alu_src_a=00, alu_src_b=00, alu_op=00.
- FETCH: alu_src_b=10, result_src=10; ir_write=pc_update=mem_ready. Stay while mem_ready=0; go to DECODE on mem_ready.
- DECODE: alu_src_a=01, alu_src_b=01 (branch target into alu_out). Next state by opcode:
  - 3 or 35 -> MEMADR
  - 51 -> EXECUTER
  - 19 -> EXECUTEI
  - 99 -> BEQ
  - 111 -> JAL (feature only)
  - else -> TRAP with illegal_op=1.
- MEMADR: alu_src_a=10, alu_src_b=01. Opcode 3 -> MEMREAD; opcode 35 -> MEMWRITE.
- MEMREAD: adr_src=1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1; mem_write=1 held until mem_ready is sampled 1, then FETCH. The write completes in that same cycle.
- EXECUTER: alu_src_a=10, alu_op=10 -> ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1 -> FETCH.
- BEQ: alu_src_a=10, alu_op=01, branch=1 -> FETCH.
- TRAP: all enables 0; held until reset.
- Instruction latency with zero-wait memory:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - I-type: 4 cycles
  - beq: 3 cycles
- Watchdog:
  - Counts consecutive cycles in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When the count equals MEM_TIMEOUT (and MEM_TIMEOUT != 0), next state is TRAP and mem_timeout=1.
  - mem_ready=1 in the expiry cycle wins: normal transition, no fault.
- Reset asserted mid-instruction returns to FETCH immediately. Partial effects are discarded; a pending write is dropped.

Optional Feature:
- Macro: CTRL_JAL_EN.
- Defined:
  - Opcode 111 is decoded.
  - JAL state: alu_src_a=01, alu_src_b=10, pc_update=1, so PC is loaded with the target from alu_out via result_src=00 and old_pc+4 is computed.
  - JAL then goes to ALUWB, which writes the link. jal takes 4 cycles.
- Undefined: opcode 111 traps as illegal; the JAL state is absent.

Decomposition:
- Package control_pkg holds:
  - State enum (FETCH..TRAP, 4-bit).
  - Opcode constants OP_LOAD=3, OP_STORE=35, OP_RTYPE=51, OP_ITYPE=19, OP_BRANCH=99, OP_JAL=111.
  - Encodings for result_src, alu_src_a, alu_src_b, imm_src and alu_op.
- One sub-module: control_imm_decoder, the combinational opcode -> imm_src mapping.

Test Plan:
- Reset, then lw (opcode 3) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 in cycle 5.
- sw (35) with mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 held for 4 cycles, then FETCH. Exactly one cycle has mem_write=1 and mem_ready=1.
- beq (99): zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. FETCH follows in both cases.
- Opcode 0x7F -> TRAP after DECODE, illegal_op=1, all enables 0; stays there until rst_n pulse clears it.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with mem_timeout=1 after 4 wait cycles. Repeat with mem_ready=1 in cycle 4 -> DECODE and no fault.
- rst_n dropped asynchronously in MEMWRITE -> mem_write=0 immediately; state_dbg=FETCH after release.
